// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
//   state_t : comparator FSM state encoding (IDLE, SHIFT, DONE)
//   gel_t   : packed {g, e, l} result triple, exactly one bit set
//   RES_*   : result encodings for greater, equal and less
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic g;
        logic e;
        logic l;
    } gel_t;

    localparam gel_t RES_GT = 3'b100;
    localparam gel_t RES_EQ = 3'b010;
    localparam gel_t RES_LT = 3'b001;

endpackage

// File: rtl/cmp_bit_cell.sv
// One MSB-first comparison step: next G/E/L from the current result and a bit pair.
// Ports:
//   cur   : current {g, e, l} result
//   a_bit : operand A bit
//   b_bit : operand B bit
//   nxt   : next {g, e, l} result (combinational)
module cmp_bit_cell
    import serial_cmp_pkg::*;
(
    input  gel_t cur,
    input  logic a_bit,
    input  logic b_bit,
    output gel_t nxt
);

    // Only the first differing bit decides; afterwards the result is frozen.
    always_comb begin
        nxt = cur;
        if (cur.e) begin
            if (a_bit && !b_bit) begin
                nxt = RES_GT;
            end else if (!a_bit && b_bit) begin
                nxt = RES_LT;
            end
        end
    end

endmodule

// File: rtl/serial_comparator.sv
// Bit-serial MSB-first magnitude comparator of two N-bit operands.
// Optional feature macro: SERIAL_CMP_EARLY_TERM_EN -- when defined, the
// comparison finishes on the first differing bit pair instead of always
// consuming all N pairs.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start              : begin a comparison (honoured in IDLE or DONE)
//   a_bit, b_bit       : operand bits, MSB first
//   bit_valid          : bit pair valid this cycle
//   bit_ready          : bit pair accepted this cycle (high in SHIFT)
//   busy               : comparison in progress
//   done               : one-cycle pulse, result final
//   G, E, L            : A > B, A == B, A < B (exactly one high)
module serial_comparator
    import serial_cmp_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic a_bit,
    input  logic b_bit,
    input  logic bit_valid,
    output logic bit_ready,
    output logic busy,
    output logic done,
    output logic G,
    output logic E,
    output logic L
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    gel_t            res;
    gel_t            res_nxt;
    logic            last_xfer_c;
    logic            stop_c;

    cmp_bit_cell u_cell (
        .cur   (res),
        .a_bit (a_bit),
        .b_bit (b_bit),
        .nxt   (res_nxt)
    );

    assign last_xfer_c = (cnt == LAST_IDX);

    // Decide whether the current transfer ends the comparison.
`ifdef SERIAL_CMP_EARLY_TERM_EN
    assign stop_c = last_xfer_c || !res_nxt.e;
`else
    assign stop_c = last_xfer_c;
`endif

    assign G = res.g;
    assign E = res.e;
    assign L = res.l;

    // Comparator FSM with registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            res       <= RES_EQ;
            bit_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_SHIFT;
                        cnt       <= '0;
                        res       <= RES_EQ;
                        bit_ready <= 1'b1;
                        busy      <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (bit_valid) begin
                        res <= res_nxt;
                        cnt <= cnt + CW'(1);
                        if (stop_c) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            bit_ready <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    bit_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_comparator.sv
// Directed self-checking bench for serial_comparator (N=16 and N=1 instances).
module tb_serial_comparator;

    localparam int unsigned N = 16;

    logic clk = 1'b0;
    logic rst;
    logic start, a_bit, b_bit, bit_valid;
    logic bit_ready, busy, done, g, e, l;

    logic start1, a1, b1, v1;
    logic bit_ready1, busy1, done1, g1, e1, l1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_comparator #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .busy      (busy),
        .done      (done),
        .G         (g),
        .E         (e),
        .L         (l)
    );

    serial_comparator #(.N(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .a_bit     (a1),
        .b_bit     (b1),
        .bit_valid (v1),
        .bit_ready (bit_ready1),
        .busy      (busy1),
        .done      (done1),
        .G         (g1),
        .E         (e1),
        .L         (l1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Number of pairs the DUT should consume for operands a/b.
    function automatic int exp_xfers(input logic [N-1:0] a, input logic [N-1:0] b);
        int n;
        n = N;
`ifdef SERIAL_CMP_EARLY_TERM_EN
        for (int i = N - 1; i >= 0; i--) begin
            if (a[i] != b[i]) begin
                n = N - i;
                break;
            end
        end
`endif
        return n;
    endfunction

    // Run one comparison; start_at >= 0 pulses start together with that transfer.
    task automatic run_cmp(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                           input bit toggle, input int start_at, input logic [2:0] exp_gel);
        int n;
        n = exp_xfers(a, b);
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_busy_on"}, 64'(busy), 64'd1);
        chk({tag, "_ready_on"}, 64'(bit_ready), 64'd1);
        chk({tag, "_cleared"}, 64'({g, e, l}), 64'(3'b010));
        for (int k = 0; k < n; k++) begin
            if (toggle) begin
                bit_valid = 1'b0;
                a_bit     = 1'b1;
                b_bit     = 1'b0;
                step();
                chk({tag, "_idle_gap_done"}, 64'(done), 64'd0);
            end
            a_bit     = a[N-1-k];
            b_bit     = b[N-1-k];
            bit_valid = 1'b1;
            start     = (k == start_at);
            step();
            start     = 1'b0;
            if (k < n - 1) begin
                chk({tag, "_no_early_done"}, 64'(done), 64'd0);
            end
        end
        bit_valid = 1'b0;
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_gel"}, 64'({g, e, l}), 64'(exp_gel));
        chk({tag, "_busy_off"}, 64'(busy), 64'd0);
        chk({tag, "_ready_off"}, 64'(bit_ready), 64'd0);
        // Bits offered in DONE/IDLE must be ignored and the result must hold.
        a_bit     = 1'b0;
        b_bit     = 1'b1;
        bit_valid = 1'b1;
        step();
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_hold_gel"}, 64'({g, e, l}), 64'(exp_gel));
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
        step();
        bit_valid = 1'b0;
        chk({tag, "_hold_gel2"}, 64'({g, e, l}), 64'(exp_gel));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; a_bit = 1'b0; b_bit = 1'b0; bit_valid = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; v1 = 1'b0;
        step();
        step();
        chk("rst_ready", 64'(bit_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_gel", 64'({g, e, l}), 64'(3'b010));
        rst = 1'b0;
        step();

        // Equal operands, continuous valid.
        run_cmp("eq", 16'h1234, 16'h1234, 1'b0, -1, 3'b010);
        // MSB decides: A greater.
        run_cmp("gt_msb", 16'h8000, 16'h7FFF, 1'b0, -1, 3'b100);
        // LSB decides, bit_valid toggling every other cycle.
        run_cmp("lt_lsb", 16'h00FE, 16'h00FF, 1'b1, -1, 3'b001);

        // Reset after 5 transfers aborts the comparison.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            a_bit = 1'b1; b_bit = 1'b1; bit_valid = 1'b1;
            step();
        end
        a_bit = 1'b0;
        rst   = 1'b1;
        start = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        bit_valid = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ready", 64'(bit_ready), 64'd0);
        chk("abort_gel", 64'({g, e, l}), 64'(3'b010));
        for (int k = 0; k < 20; k++) begin
            step();
            chk("abort_no_done", 64'(done), 64'd0);
        end
        run_cmp("after_rst", 16'hA5A5, 16'hA5A4, 1'b0, -1, 3'b100);

        // start pulsed with the 4th transfer must be ignored.
        run_cmp("start_in_shift", 16'h0F0F, 16'h0F10, 1'b0, 3, 3'b001);

        // N=1 instance: single transfer then DONE.
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        chk("n1_ready", 64'(bit_ready1), 64'd1);
        a1 = 1'b0; b1 = 1'b1; v1 = 1'b1;
        step();
        v1 = 1'b0;
        chk("n1_done", 64'(done1), 64'd1);
        chk("n1_gel", 64'({g1, e1, l1}), 64'(3'b001));
        chk("n1_ready_off", 64'(bit_ready1), 64'd0);
        step();
        chk("n1_done_pulse", 64'(done1), 64'd0);
        chk("n1_hold_gel", 64'({g1, e1, l1}), 64'(3'b001));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_comparator.md
SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 Parameter N, default 16: operand width in bits, legal range 1..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  begins a new comparison when sampled high in IDLE or DONE.
REQ-005 a_bit  input  1  operand A bit, MSB first.
REQ-006 b_bit  input  1  operand B bit, MSB first.
REQ-007 bit_valid  input  1  a_bit/b_bit pair valid this cycle.
REQ-008 bit_ready  output  1  block accepts a bit pair this cycle.
REQ-009 busy  output  1  comparison in progress.
REQ-010 done  output  1  single-cycle pulse; result final.
REQ-011 G  output  1  A > B.
REQ-012 E  output  1  A == B.
REQ-013 L  output  1  A < B.

Function
REQ-014 FSM states IDLE, SHIFT, DONE; exactly one state active.
REQ-015 IDLE/DONE + start -> SHIFT; clears bit counter; sets G=0, E=1, L=0 on same edge.
REQ-016 In SHIFT, bit_ready=1 and busy=1; transfer occurs when bit_valid && bit_ready.
REQ-017 Per transfer while E=1: a_bit>b_bit -> G=1,E=0; a_bit<b_bit -> L=1,E=0; equal -> unchanged.
REQ-018 Once E=0, later transfers do not change G/E/L (first differing MSB decides).
REQ-019 Bit counter width clog2(N+1); increments per transfer; no wrap.
REQ-020 Transfer number N -> DONE on that edge; done=1 for exactly the cycle in DONE.
REQ-021 Latency: done high the cycle after the Nth transfer; no bubbles required between transfers.
REQ-022 DONE with start=0 -> IDLE next cycle; G/E/L hold until next start.
REQ-023 start in SHIFT ignored; bit_valid in IDLE/DONE ignored (bit_ready=0 there).
REQ-024 Exactly one of G/E/L high at all times after reset.
REQ-025 N=1: single transfer then DONE.

Reset
REQ-026 rst: state IDLE, counter 0, bit_ready=0, busy=0, done=0, G=0, E=1, L=0.
REQ-027 rst mid-SHIFT aborts comparison; partial result discarded; rst dominates start.

Configuration
REQ-028 Macro SERIAL_CMP_EARLY_TERM_EN.
REQ-029 Defined: SHIFT -> DONE on the transfer where E first clears; remaining bits not accepted; sender must abort its stream on done.
REQ-030 Undefined: all N bit pairs always consumed; done timing independent of data.

Structure
REQ-031 Shared package serial_cmp_pkg holds state enum typedef and result-encoding constants (G/E/L).
REQ-032 One sub-module cmp_bit_cell: combinational next G/E/L from current G/E/L and a_bit/b_bit.

Verification
REQ-033 N=16, A=0x1234, B=0x1234, continuous valid -> done on cycle 17 after first transfer, E=1, G=0, L=0.
REQ-034 N=16, A=0x8000, B=0x7FFF -> G=1; with EARLY_TERM_EN done one cycle after first transfer; without, after 16th.
REQ-035 N=16, A=0x00FE, B=0x00FF, bit_valid toggling every other cycle -> L=1, done one cycle after 16th transfer.
REQ-036 rst asserted after 5 transfers -> IDLE, E=1, done never pulses; new start plus 16 transfers yields correct result.
REQ-037 start pulsed in SHIFT after 3 transfers -> ignored; counter continues, result matches original operands.
REQ-038 N=1, a_bit=0, b_bit=1 -> L=1, done one cycle after single transfer.
